midi_merge_rr: RTL and testbench
================================

Name: midi_merge_rr

Overview:
Parametrised N-port MIDI merger acting as a Wishbone master. It polls N MIDI receiver slaves round-robin and forwards their bytes to one MIDI transmitter slave. Merging is message-atomic: a channel or SysEx message is never interleaved with bytes from another port. The block restores running status per port and releases a stalled port on timeout. It sits between the per-port MIDI UART slaves and the merged-output UART on the shared 8-bit Wishbone bus.

Parameters:
N_PORTS, 4, number of input ports (1..8)
ADDR_IN_BASE, 8'h00, Wishbone address of port 0 status register
ADDR_STRIDE, 8'h04, address distance between input ports
ADDR_OUT, 8'h40, Wishbone address of output transmitter status register
TIMEOUT_CYC, 16'd50000, idle cycles allowed mid-message before lock release

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
wb_addr  out  8  Wishbone address
wb_dat_i  in  8  read data from slave
wb_dat_o  out  8  write data to slave
wb_we_o  out  1  1 = write cycle
wb_stb_o  out  1  strobe, held until ack
wb_ack_i  in  1  slave acknowledge

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values: wb_stb_o=0, wb_we_o=0, wb_addr=0, wb_dat_o=0, port pointer=0, lock cleared, all per-port running status=none, out_last_status=none, timeout counter=0.
- Slave register map: base+0 status (bit0 RX_AVAIL, bit1 TX_READY); base+1 data.
- Bus rules:
  - addr, dat_o and we are driven stable for the whole cycle while stb=1.
  - The cycle ends on the clock where ack=1.
  - stb is low for at least one clock between cycles.
  - No cycle timeout; a missing ack stalls the FSM.
- FSM:
  - SEL: pick a port. If locked, use the locked port; else the port pointer.
  - RD_ST: read the input status of the selected port.
    - RX_AVAIL=0 and unlocked: advance pointer (mod N_PORTS) -> SEL.
    - RX_AVAIL=0 and locked: -> SEL. The timeout counter keeps counting.
    - RX_AVAIL=1: -> RD_DAT.
  - RD_DAT: read the byte -> CLASSIFY.
  - CLASSIFY: apply the byte rules below -> WAIT_TX (with the byte queued) or SEL (byte dropped).
  - WAIT_TX: read ADDR_OUT repeatedly until TX_READY=1 -> WR_DAT.
  - WR_DAT: write to ADDR_OUT+1. Then go to the next queued byte (inserted status, then data) or to SEL.
- Byte rules (per-port state rs[i] and remaining-count rem):
  - 0xF8-0xFF realtime: forwarded immediately. Lock, rem and rs are unchanged.
  - 0x80-0xEF channel status:
    - Set rs[i] and rem (2, or 1 for 0xC0-0xDF).
    - Lock port i and forward.
    - Set out_last_status to this status.
  - 0xF0: lock in sysex mode, forward, rs[i]=none, out_last_status=none.
  - 0xF7: forward, unlock.
  - 0xF1/0xF3: rem=1. 0xF2: rem=2. 0xF4/F5/F6: rem=0.
    - All system common bytes clear rs[i] and out_last_status.
    - All lock while rem>0 and are forwarded.
  - Data 0x00-0x7F, locked: forward and decrement rem. Unlock at rem=0, except in sysex mode.
  - Data 0x00-0x7F, unlocked, rs[i] valid:
    - Lock and reload rem from rs[i].
    - If out_last_status != rs[i], first emit rs[i] and set out_last_status; then forward the data byte.
  - Data 0x00-0x7F, unlocked, rs[i]=none: drop.
- Unlock always advances the pointer, giving round-robin fairness.
- Timeout:
  - The counter counts clocks while locked with no byte accepted from the locked port. It resets on each accepted byte.
  - At TIMEOUT_CYC: unlock. In sysex mode, first emit 0xF7. The partial message is abandoned and rs[i] is kept.
- rst mid-cycle: stb drops on the next clock and all state returns to reset values. No byte is re-sent.

Decomposition:
- Package midi_pkg: MIDI byte constants (0xF0, 0xF7, 0xF8 realtime floor), register offsets, status bit indices, FSM state encoding.
- Function midi_data_len(status) -> 0..2 goes in the package.
- Sub-module wb_master_if: single-transfer Wishbone master. Req/we/addr/data in; done/rdata out; enforces the stb/ack rules.

Test Plan:
- Port 0 sends 0x90 0x3C 0x64 -> output writes 0x90, 0x3C, 0x64 in order; exactly 3 writes to ADDR_OUT+1.
- Port 0 sends 0x90 0x3C, then port 1 sends 0xB0 0x07 0x7F before port 0 sends 0x40 -> output is 0x90 0x3C 0x40 0xB0 0x07 0x7F. Port 1's bytes stay pending in the slave and are not read during the lock.
- Port 0 mid-note (0x90 0x3C) receives 0xF8 -> output 0x90 0x3C 0xF8; the following 0x40 still completes the note and the lock is held.
- Running status: port 0 sends 0x90 0x3C 0x40; port 1 sends 0x80 0x3C 0x00; port 0 sends 0x3E 0x40 -> output ends with 0x90 0x3E 0x40 (status re-inserted).
- Port 2 sends 0xF0 0x7E, then is silent for TIMEOUT_CYC -> output 0xF0 0x7E 0xF7; the next poll is at port 3.
- rst=1 for 1 clock during WAIT_TX -> wb_stb_o=0 on the next clock; after release, polling restarts at port 0 and rs for all ports is none.

Source files
------------

// File: rtl/midi_pkg.sv
// Shared MIDI byte constants, slave register layout and merger FSM encoding.
package midi_pkg;
   localparam logic [7:0] MIDI_STATUS_FLOOR = 8'h80;
   localparam logic [7:0] MIDI_SYSEX_START  = 8'hF0;
   localparam logic [7:0] MIDI_SYSEX_END    = 8'hF7;
   localparam logic [7:0] MIDI_RT_FLOOR     = 8'hF8;

   localparam logic [7:0] REG_STATUS = 8'h00;
   localparam logic [7:0] REG_DATA   = 8'h01;
   localparam int ST_RX_AVAIL = 0;
   localparam int ST_TX_READY = 1;

   typedef enum logic [2:0] {
      S_SEL, S_RD_ST, S_RD_DAT, S_CLASSIFY, S_WAIT_TX, S_WR_DAT
   } merge_state_t;

   // Number of data bytes that follow a status byte (0 for anything without a fixed count).
   function automatic logic [1:0] midi_data_len(input logic [7:0] status);
      logic [1:0] len;
      len = 2'd0;
      if (status >= MIDI_STATUS_FLOOR && status < MIDI_SYSEX_START)
         len = (status[7:5] == 3'b110) ? 2'd1 : 2'd2;
      else if (status == 8'hF1 || status == 8'hF3)
         len = 2'd1;
      else if (status == 8'hF2)
         len = 2'd2;
      return len;
   endfunction
endpackage

// File: rtl/wb_master_if.sv
// Single-transfer Wishbone master: latches a request, holds stb until ack, then idles a clock.
module wb_master_if (
   input  logic       clk,
   input  logic       rst,
   input  logic       req,
   input  logic       we,
   input  logic [7:0] addr,
   input  logic [7:0] wdata,
   output logic       done,
   output logic [7:0] rdata,
   output logic [7:0] wb_addr,
   output logic [7:0] wb_dat_o,
   output logic       wb_we_o,
   output logic       wb_stb_o,
   input  logic [7:0] wb_dat_i,
   input  logic       wb_ack_i
);
   // A new cycle can only start from stb=0, so the gap clock between cycles is automatic.
   always_ff @(posedge clk) begin
      if (rst) begin
         wb_stb_o <= 1'b0;
         wb_we_o  <= 1'b0;
         wb_addr  <= 8'h00;
         wb_dat_o <= 8'h00;
      end else if (wb_stb_o) begin
         if (wb_ack_i) begin
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
         end
      end else if (req) begin
         wb_stb_o <= 1'b1;
         wb_we_o  <= we;
         wb_addr  <= addr;
         wb_dat_o <= wdata;
      end
   end

   assign done  = wb_stb_o & wb_ack_i;
   assign rdata = wb_dat_i;
endmodule

// File: rtl/midi_merge_rr.sv
// Round-robin, message-atomic MIDI merger: polls N receiver slaves and forwards to one transmitter.
module midi_merge_rr
   import midi_pkg::*;
#(
   parameter int          N_PORTS      = 4,
   parameter logic [7:0]  ADDR_IN_BASE = 8'h00,
   parameter logic [7:0]  ADDR_STRIDE  = 8'h04,
   parameter logic [7:0]  ADDR_OUT     = 8'h40,
   parameter logic [15:0] TIMEOUT_CYC  = 16'd50000
) (
   input  logic       clk,
   input  logic       rst,
   output logic [7:0] wb_addr,
   input  logic [7:0] wb_dat_i,
   output logic [7:0] wb_dat_o,
   output logic       wb_we_o,
   output logic       wb_stb_o,
   input  logic       wb_ack_i
);
   localparam int PW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

   merge_state_t state, state_nxt;
   logic               req, we, done;
   logic [7:0]         addr, wdata, rdata;
   logic [PW-1:0]      ptr, cur, lock_port;
   logic               lock, sysex;
   logic [1:0]         rem;
   logic [N_PORTS-1:0] rs_vld;
   logic [N_PORTS-1:0][7:0] rs_val;
   logic               ols_vld;
   logic [7:0]         ols_val;
   logic [15:0]        tmo_cnt;
   logic [7:0]         rx_byte, q0, q1;
   logic [1:0]         qn;
   logic [7:0]         in_base;
   logic               tmo_fire;

   logic [7:0] c_q0, c_q1, c_rs_val, c_ols_val;
   logic [1:0] c_qn, c_rem;
   logic       c_lock, c_sysex, c_rs_wr, c_rs_vld, c_ols_vld, c_adv;

   function automatic logic [PW-1:0] nxt_port(input logic [PW-1:0] p);
      return (int'(p) == N_PORTS - 1) ? '0 : p + 1'b1;
   endfunction

   assign in_base  = ADDR_IN_BASE + ADDR_STRIDE * {{(8-PW){1'b0}}, cur};
   assign tmo_fire = lock && (tmo_cnt == TIMEOUT_CYC);

   wb_master_if u_wb (
      .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
      .done(done), .rdata(rdata),
      .wb_addr(wb_addr), .wb_dat_o(wb_dat_o), .wb_we_o(wb_we_o), .wb_stb_o(wb_stb_o),
      .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i)
   );

   // Byte classification for the byte just read from port cur.
   always_comb begin
      c_qn = 2'd0;  c_q0 = rx_byte;  c_q1 = rx_byte;
      c_lock = lock;  c_rem = rem;  c_sysex = sysex;
      c_rs_wr = 1'b0;  c_rs_vld = rs_vld[cur];  c_rs_val = rs_val[cur];
      c_ols_vld = ols_vld;  c_ols_val = ols_val;
      c_adv = 1'b0;
      if (rx_byte >= MIDI_RT_FLOOR) begin
         c_qn = 2'd1;
      end else if (rx_byte < MIDI_STATUS_FLOOR) begin
         if (lock) begin
            c_qn = 2'd1;
            if (!sysex) begin
               c_rem  = rem - 2'd1;
               c_lock = (rem > 2'd1);
            end
         end else if (rs_vld[cur]) begin
            c_rem  = midi_data_len(rs_val[cur]) - 2'd1;
            c_lock = (c_rem != 2'd0);
            c_adv  = !c_lock;
            if (!ols_vld || ols_val != rs_val[cur]) begin
               c_qn = 2'd2;  c_q0 = rs_val[cur];  c_q1 = rx_byte;
               c_ols_vld = 1'b1;  c_ols_val = rs_val[cur];
            end else begin
               c_qn = 2'd1;
            end
         end
      end else if (rx_byte < MIDI_SYSEX_START) begin
         c_qn = 2'd1;  c_lock = 1'b1;  c_sysex = 1'b0;
         c_rem = midi_data_len(rx_byte);
         c_rs_wr = 1'b1;  c_rs_vld = 1'b1;  c_rs_val = rx_byte;
         c_ols_vld = 1'b1;  c_ols_val = rx_byte;
      end else if (rx_byte == MIDI_SYSEX_START) begin
         c_qn = 2'd1;  c_lock = 1'b1;  c_sysex = 1'b1;  c_rem = 2'd0;
         c_rs_wr = 1'b1;  c_rs_vld = 1'b0;  c_ols_vld = 1'b0;
      end else if (rx_byte == MIDI_SYSEX_END) begin
         c_qn = 2'd1;  c_lock = 1'b0;  c_sysex = 1'b0;  c_rem = 2'd0;
      end else begin
         c_qn = 2'd1;  c_sysex = 1'b0;
         c_rem = midi_data_len(rx_byte);
         c_lock = (c_rem != 2'd0);
         c_rs_wr = 1'b1;  c_rs_vld = 1'b0;  c_ols_vld = 1'b0;
      end
      if (lock && !c_lock)
         c_adv = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) state <= S_SEL;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      req = 1'b0;  we = 1'b0;  addr = 8'h00;  wdata = q0;
      case (state)
         S_SEL:      state_nxt = tmo_fire ? (sysex ? S_WAIT_TX : S_SEL) : S_RD_ST;
         S_RD_ST: begin
            req = 1'b1;  addr = in_base + REG_STATUS;
            if (done) state_nxt = rdata[ST_RX_AVAIL] ? S_RD_DAT : S_SEL;
         end
         S_RD_DAT: begin
            req = 1'b1;  addr = in_base + REG_DATA;
            if (done) state_nxt = S_CLASSIFY;
         end
         S_CLASSIFY: state_nxt = (c_qn != 2'd0) ? S_WAIT_TX : S_SEL;
         S_WAIT_TX: begin
            req = 1'b1;  addr = ADDR_OUT + REG_STATUS;
            if (done && rdata[ST_TX_READY]) state_nxt = S_WR_DAT;
         end
         S_WR_DAT: begin
            req = 1'b1;  we = 1'b1;  addr = ADDR_OUT + REG_DATA;
            if (done) state_nxt = (qn == 2'd2) ? S_WAIT_TX : S_SEL;
         end
         default:    state_nxt = S_SEL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr <= '0;  cur <= '0;  lock_port <= '0;
         lock <= 1'b0;  sysex <= 1'b0;  rem <= 2'd0;
         rs_vld <= '0;  rs_val <= '0;
         ols_vld <= 1'b0;  ols_val <= 8'h00;
         tmo_cnt <= 16'd0;
         rx_byte <= 8'h00;  q0 <= 8'h00;  q1 <= 8'h00;  qn <= 2'd0;
      end else begin
         // Any byte taken from the locked port restarts the stall timer.
         if (!lock || state == S_CLASSIFY)  tmo_cnt <= 16'd0;
         else if (tmo_cnt != TIMEOUT_CYC)   tmo_cnt <= tmo_cnt + 16'd1;
         case (state)
            S_SEL: begin
               if (tmo_fire) begin
                  lock <= 1'b0;  sysex <= 1'b0;  rem <= 2'd0;
                  ptr  <= nxt_port(lock_port);
                  if (sysex) begin
                     q0 <= MIDI_SYSEX_END;  qn <= 2'd1;
                  end
               end else begin
                  cur <= lock ? lock_port : ptr;
               end
            end
            S_RD_ST:
               if (done && !rdata[ST_RX_AVAIL] && !lock) ptr <= nxt_port(ptr);
            S_RD_DAT:
               if (done) rx_byte <= rdata;
            S_CLASSIFY: begin
               q0 <= c_q0;  q1 <= c_q1;  qn <= c_qn;
               lock <= c_lock;  rem <= c_rem;  sysex <= c_sysex;
               if (c_lock && !lock) lock_port <= cur;
               if (c_rs_wr) begin
                  rs_vld[cur] <= c_rs_vld;
                  rs_val[cur] <= c_rs_val;
               end
               ols_vld <= c_ols_vld;  ols_val <= c_ols_val;
               if (c_adv) ptr <= nxt_port(cur);
            end
            S_WR_DAT:
               if (done) begin
                  q0 <= q1;  qn <= qn - 2'd1;
               end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_midi_merge_rr.sv
// Scoreboard bench: Wishbone slave models for 4 input UARTs and the output UART.
module tb_midi_merge_rr;
   localparam int NP = 4;
   localparam logic [7:0] A_OUT = 8'h40;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] wb_addr, wb_dat_o;
   logic [7:0] wb_dat_i = 8'h00;
   logic       wb_we_o, wb_stb_o;
   logic       wb_ack_i = 1'b0;

   midi_merge_rr #(
      .N_PORTS(NP), .ADDR_IN_BASE(8'h00), .ADDR_STRIDE(8'h04),
      .ADDR_OUT(A_OUT), .TIMEOUT_CYC(16'd200)
   ) dut (
      .clk(clk), .rst(rst), .wb_addr(wb_addr), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
      .wb_we_o(wb_we_o), .wb_stb_o(wb_stb_o), .wb_ack_i(wb_ack_i)
   );

   always #5 clk = ~clk;

   int         total = 0, bad = 0, wr_cnt = 0;
   bit         tx_ready = 1'b1;
   logic [7:0] rx_q [NP][$];
   logic [7:0] exp_q [$];
   int         rd_dat_cnt [NP];
   bit         arm_rd = 1'b0, arm_on_f7 = 1'b0, rd_seen = 1'b0;
   logic [7:0] rd_addr_seen = 8'h00;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
      end
   endtask

   // Slave responder: acks one clock after stb is seen, models RX FIFOs and TX_READY.
   initial forever begin
      int p;
      @(posedge clk); #1;
      if (wb_stb_o && !wb_ack_i) begin
         wb_ack_i = 1'b1;
         wb_dat_i = 8'h00;
         if (wb_addr == A_OUT) begin
            wb_dat_i = {6'd0, tx_ready, 1'b0};
         end else if (wb_addr < A_OUT) begin
            p = int'(wb_addr >> 2);
            if (p < NP && wb_addr[1:0] == 2'd0) begin
               wb_dat_i = {7'd0, (rx_q[p].size() != 0)};
               if (arm_rd && !rst) begin
                  rd_addr_seen = wb_addr;  rd_seen = 1'b1;  arm_rd = 1'b0;
               end
            end else if (p < NP && wb_addr[1:0] == 2'd1 && !wb_we_o) begin
               rd_dat_cnt[p]++;
               if (rx_q[p].size() != 0) wb_dat_i = rx_q[p].pop_front();
            end
         end
      end else begin
         wb_ack_i = 1'b0;
      end
   end

   // Monitor: every acked write to the output data register is checked against the scoreboard.
   initial forever begin
      @(negedge clk);
      if (wb_stb_o && wb_ack_i && wb_we_o && wb_addr == A_OUT + 8'd1) begin
         wr_cnt++;
         if (exp_q.size() == 0) begin
            total++;  bad++;
            $display("FAIL out_byte: got 0x%0h want no write", wb_dat_o);
         end else begin
            check("out_byte", wb_dat_o, exp_q.pop_front());
         end
         if (wb_dat_o == 8'hF7 && arm_on_f7) begin
            arm_rd = 1'b1;  arm_on_f7 = 1'b0;
         end
      end
   end

   task automatic push(input int p, input logic [7:0] b);
      rx_q[p].push_back(b);
   endtask

   task automatic expect_b(input logic [7:0] b);
      exp_q.push_back(b);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
   endtask

   task automatic wait_wr(input int n, input string name);
      int k;
      k = 0;
      while (wr_cnt < n && k < 3000) begin
         @(posedge clk);
         k++;
      end
      idle(2);
      check(name, wr_cnt, n);
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      foreach (rx_q[i]) rx_q[i].delete();
      foreach (rd_dat_cnt[i]) rd_dat_cnt[i] = 0;
      exp_q.delete();
      tx_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      wr_cnt = 0;
      rst = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      foreach (rd_dat_cnt[i]) rd_dat_cnt[i] = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_stb", wb_stb_o, 0);
      check("rst_we", wb_we_o, 0);
      check("rst_addr", wb_addr, 0);
      check("rst_dat_o", wb_dat_o, 0);

      // Simple note-on passes through, exactly three writes.
      do_reset();
      push(0, 8'h90); push(0, 8'h3C); push(0, 8'h64);
      expect_b(8'h90); expect_b(8'h3C); expect_b(8'h64);
      wait_wr(3, "t1_writes");
      idle(50);
      check("t1_exact_writes", wr_cnt, 3);

      // Port 1 must wait while port 0 holds a partial message.
      do_reset();
      push(0, 8'h90); push(0, 8'h3C);
      expect_b(8'h90); expect_b(8'h3C); expect_b(8'h40);
      expect_b(8'hB0); expect_b(8'h07); expect_b(8'h7F);
      wait_wr(2, "t2_first_two");
      push(1, 8'hB0); push(1, 8'h07); push(1, 8'h7F);
      idle(100);
      check("t2_p1_not_read", rd_dat_cnt[1], 0);
      check("t2_held_writes", wr_cnt, 2);
      push(0, 8'h40);
      wait_wr(6, "t2_all");

      // Realtime inside a message keeps the lock.
      do_reset();
      push(0, 8'h90); push(0, 8'h3C);
      expect_b(8'h90); expect_b(8'h3C); expect_b(8'hF8); expect_b(8'h40);
      expect_b(8'hB0); expect_b(8'h07); expect_b(8'h7F);
      wait_wr(2, "t3_first_two");
      push(0, 8'hF8);
      wait_wr(3, "t3_realtime");
      push(1, 8'hB0); push(1, 8'h07); push(1, 8'h7F);
      idle(60);
      check("t3_lock_held", rd_dat_cnt[1], 0);
      push(0, 8'h40);
      wait_wr(7, "t3_all");

      // Running status re-inserted after another port changed the output status.
      do_reset();
      push(0, 8'h90); push(0, 8'h3C); push(0, 8'h40);
      expect_b(8'h90); expect_b(8'h3C); expect_b(8'h40);
      wait_wr(3, "t4_p0");
      push(1, 8'h80); push(1, 8'h3C); push(1, 8'h00);
      expect_b(8'h80); expect_b(8'h3C); expect_b(8'h00);
      wait_wr(6, "t4_p1");
      push(0, 8'h3E); push(0, 8'h40);
      expect_b(8'h90); expect_b(8'h3E); expect_b(8'h40);
      wait_wr(9, "t4_running");

      // Stalled SysEx is closed with F7 and polling moves on to the next port.
      do_reset();
      rd_seen = 1'b0;  arm_on_f7 = 1'b1;
      push(2, 8'hF0); push(2, 8'h7E);
      expect_b(8'hF0); expect_b(8'h7E); expect_b(8'hF7);
      wait_wr(3, "t5_timeout");
      idle(20);
      check("t5_next_seen", rd_seen, 1);
      check("t5_next_port_addr", rd_addr_seen, 8'h0C);

      // Reset while waiting for TX_READY.
      do_reset();
      tx_ready = 1'b0;
      push(0, 8'h90); push(0, 8'h3C);
      k = 0;
      while (!(wb_stb_o && wb_addr == A_OUT) && k < 500) begin
         @(posedge clk); #1;
         k++;
      end
      check("t6_in_wait_tx", (wb_stb_o && wb_addr == A_OUT), 1);
      rst = 1'b1;
      rd_seen = 1'b0;  arm_rd = 1'b1;
      @(posedge clk); #1;
      check("t6_stb_drop", wb_stb_o, 0);
      exp_q.delete();
      wr_cnt = 0;
      tx_ready = 1'b1;
      rst = 1'b0;
      idle(100);
      check("t6_restart_port0", rd_addr_seen, 8'h00);
      check("t6_restart_seen", rd_seen, 1);
      check("t6_no_resend", wr_cnt, 0);
      push(0, 8'h45);
      idle(50);
      check("t6_rs_none_drop", wr_cnt, 0);
      push(0, 8'hC0); push(0, 8'h05);
      expect_b(8'hC0); expect_b(8'h05);
      wait_wr(2, "t6_after_reset");

      idle(20);
      check("scoreboard_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
